// File: rtl/joystick_cmd_ctrl_if.sv
// Command handshake between joystick_cmd_ctrl (master) and the game-state FSM (slave).
// Latency: n/a (wires only).
// Backpressure: cmd_ready low holds cmd_valid and the payload stable.
// Signals: cmd_valid, cmd_move, cmd_dir[1:0], cmd_fire (master->slave), cmd_ready (slave->master).
interface joystick_cmd_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_move;
   logic [1:0] cmd_dir;
   logic       cmd_fire;

   modport master (
      output cmd_valid,
      output cmd_move,
      output cmd_dir,
      output cmd_fire,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_move,
      input  cmd_dir,
      input  cmd_fire,
      output cmd_ready
   );
endinterface

// File: rtl/joystick_cmd_ctrl.sv
// Turns debounced joystick levels into move (with auto-repeat) and rate-limited fire commands.
// Latency: input sampled at edge k gives cmd_valid after edge k+1.
// Backpressure: while valid && !ready the payload holds; new events are dropped and counted.
// Ports: clk, rst_n (sync, active-low); i_up/i_down/i_left/i_right/i_fire levels;
//        cmd (master modport: valid/ready, move, dir, fire); o_drop_cnt saturating drop count.
module joystick_cmd_ctrl #(
   parameter int CNT_W         = 25,
   parameter int REPEAT_DELAY  = 25_000_000,
   parameter int REPEAT_RATE   = 5_000_000,
   parameter int FIRE_COOLDOWN = 10_000_000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_up,
   input  logic                 i_down,
   input  logic                 i_left,
   input  logic                 i_right,
   input  logic                 i_fire,
   joystick_cmd_ctrl_if.master  cmd,
   output logic [7:0]           o_drop_cnt
);

   localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);
   localparam logic [CNT_W-1:0] COOL_LOAD  = CNT_W'(FIRE_COOLDOWN);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   // input sample registers
   logic [3:0]       s_dir_q, s_dir_d;     // {right, left, down, up}
   logic             s_fire_q, s_fire_d;
   logic             fire_prev_q, fire_prev_d;

   // direction FSM
   state_t           state_q, state_d;
   logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
   logic [1:0]       dir_q, dir_d;

   // fire cooldown
   logic [CNT_W-1:0] cool_cnt_q, cool_cnt_d;

   // command register
   logic             cmd_vld_q, cmd_vld_d;
   logic             cmd_move_q, cmd_move_d;
   logic [1:0]       cmd_dir_q, cmd_dir_d;
   logic             cmd_fire_q, cmd_fire_d;
   logic [7:0]       drop_cnt_q, drop_cnt_d;

   logic             any_dir;
   logic [1:0]       sel_dir;
   logic             move_evt;
   logic             fire_evt;
   logic             can_load;

   always_comb begin
      s_dir_d     = {i_right, i_left, i_down, i_up};
      s_fire_d    = i_fire;
      fire_prev_d = s_fire_q;

      any_dir = |s_dir_q;
      if (s_dir_q[0])      sel_dir = 2'b00;
      else if (s_dir_q[1]) sel_dir = 2'b01;
      else if (s_dir_q[2]) sel_dir = 2'b10;
      else                 sel_dir = 2'b11;

      // direction FSM
      move_evt  = 1'b0;
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      dir_d     = dir_q;
      case (state_q)
         ST_DELAY, ST_REPEAT: begin
            if (!any_dir) begin
               state_d = ST_IDLE;
            end else if (sel_dir != dir_q) begin
               // a change of winning direction behaves like a fresh press
               move_evt  = 1'b1;
               dir_d     = sel_dir;
               rpt_cnt_d = DELAY_LOAD;
               state_d   = ST_DELAY;
            end else if (rpt_cnt_q == '0) begin
               move_evt  = 1'b1;
               rpt_cnt_d = RATE_LOAD;
               state_d   = ST_REPEAT;
            end else begin
               rpt_cnt_d = rpt_cnt_q - 1'b1;
            end
         end
         default: begin
            if (any_dir) begin
               move_evt  = 1'b1;
               dir_d     = sel_dir;
               rpt_cnt_d = DELAY_LOAD;
               state_d   = ST_DELAY;
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase

      // fire: rising edge only, gated by cooldown; cooldown arms even if the
      // resulting command is later dropped by backpressure
      fire_evt = s_fire_q && !fire_prev_q && (cool_cnt_q == '0);
      if (fire_evt)               cool_cnt_d = COOL_LOAD;
      else if (cool_cnt_q != '0)  cool_cnt_d = cool_cnt_q - 1'b1;
      else                        cool_cnt_d = cool_cnt_q;

      // command register: free when empty or being drained this cycle
      can_load   = !cmd_vld_q || cmd.cmd_ready;
      cmd_vld_d  = cmd_vld_q;
      cmd_move_d = cmd_move_q;
      cmd_dir_d  = cmd_dir_q;
      cmd_fire_d = cmd_fire_q;
      drop_cnt_d = drop_cnt_q;
      if (can_load) begin
         cmd_vld_d = move_evt || fire_evt;
         if (move_evt || fire_evt) begin
            cmd_move_d = move_evt;
            cmd_dir_d  = move_evt ? dir_d : 2'b00;
            cmd_fire_d = fire_evt;
         end
      end else if ((move_evt || fire_evt) && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_dir_q     <= '0;
         s_fire_q    <= 1'b0;
         fire_prev_q <= 1'b0;
         state_q     <= ST_IDLE;
         rpt_cnt_q   <= '0;
         dir_q       <= 2'b00;
         cool_cnt_q  <= '0;
         cmd_vld_q   <= 1'b0;
         cmd_move_q  <= 1'b0;
         cmd_dir_q   <= 2'b00;
         cmd_fire_q  <= 1'b0;
         drop_cnt_q  <= 8'd0;
      end else begin
         s_dir_q     <= s_dir_d;
         s_fire_q    <= s_fire_d;
         fire_prev_q <= fire_prev_d;
         state_q     <= state_d;
         rpt_cnt_q   <= rpt_cnt_d;
         dir_q       <= dir_d;
         cool_cnt_q  <= cool_cnt_d;
         cmd_vld_q   <= cmd_vld_d;
         cmd_move_q  <= cmd_move_d;
         cmd_dir_q   <= cmd_dir_d;
         cmd_fire_q  <= cmd_fire_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign cmd.cmd_valid = cmd_vld_q;
   assign cmd.cmd_move  = cmd_move_q;
   assign cmd.cmd_dir   = cmd_dir_q;
   assign cmd.cmd_fire  = cmd_fire_q;
   assign o_drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_joystick_cmd_ctrl.sv
// Scoreboard bench for joystick_cmd_ctrl with short timing parameters.
// Expected commands (payload + arrival cycle) are queued as stimulus is driven.
// A negedge monitor pops and compares on every transfer.
module tb_joystick_cmd_ctrl;

   logic       clk;
   logic       rst_n;
   logic       i_up, i_down, i_left, i_right, i_fire;
   logic [7:0] o_drop_cnt;
   int         cyc;
   int         n_chk;
   int         n_err;
   int         t;

   typedef struct {
      logic       move;
      logic [1:0] dir;
      logic       fire;
      int         at;
   } exp_t;

   exp_t exp_q[$];

   joystick_cmd_ctrl_if cmd_if ();

   joystick_cmd_ctrl #(
      .CNT_W        (25),
      .REPEAT_DELAY (8),
      .REPEAT_RATE  (4),
      .FIRE_COOLDOWN(6)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_up      (i_up),
      .i_down    (i_down),
      .i_left    (i_left),
      .i_right   (i_right),
      .i_fire    (i_fire),
      .cmd       (cmd_if.master),
      .o_drop_cnt(o_drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (got !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_exp(input logic m, input logic [1:0] d, input logic f, input int at);
      exp_t e;
      e.move = m;
      e.dir  = d;
      e.fire = f;
      e.at   = at;
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // transfer monitor
   always @(negedge clk) begin
      if (rst_n && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_cmd", 32'(cyc), 32'(-1));
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_eq("cmd_cycle", 32'(cyc), 32'(e.at));
            check_eq("cmd_move", 32'(cmd_if.cmd_move), 32'(e.move));
            if (e.move) check_eq("cmd_dir", 32'(cmd_if.cmd_dir), 32'(e.dir));
            check_eq("cmd_fire", 32'(cmd_if.cmd_fire), 32'(e.fire));
         end
      end
   end

   initial begin
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      {i_up, i_down, i_left, i_right, i_fire} = '0;
      cmd_if.cmd_ready = 1'b1;

      // reset state
      tick(3);
      check_eq("rst_valid", 32'(cmd_if.cmd_valid), 32'd0);
      check_eq("rst_move", 32'(cmd_if.cmd_move), 32'd0);
      check_eq("rst_dir", 32'(cmd_if.cmd_dir), 32'd0);
      check_eq("rst_fire", 32'(cmd_if.cmd_fire), 32'd0);
      check_eq("rst_drop", 32'(o_drop_cnt), 32'd0);
      rst_n = 1'b1;
      tick(2);

      // 1: short up press -> one command
      t = cyc;
      i_up = 1'b1;
      push_exp(1'b1, 2'b00, 1'b0, t + 2);
      tick(3);
      i_up = 1'b0;
      tick(12);

      // 2: right held 20 cycles -> t, +8, +12, +16 (relative to first event)
      t = cyc;
      i_right = 1'b1;
      push_exp(1'b1, 2'b11, 1'b0, t + 2);
      push_exp(1'b1, 2'b11, 1'b0, t + 10);
      push_exp(1'b1, 2'b11, 1'b0, t + 14);
      push_exp(1'b1, 2'b11, 1'b0, t + 18);
      tick(20);
      i_right = 1'b0;
      tick(10);

      // 3: up+left, release up -> up, then immediate left, repeat restarts from 8
      t = cyc;
      i_up = 1'b1;
      i_left = 1'b1;
      push_exp(1'b1, 2'b00, 1'b0, t + 2);
      tick(3);
      i_up = 1'b0;
      push_exp(1'b1, 2'b10, 1'b0, t + 5);
      push_exp(1'b1, 2'b10, 1'b0, t + 13);
      tick(10);
      i_left = 1'b0;
      tick(10);

      // 4: fire edges at t, t+3, t+7 -> only t and t+7 issue
      t = cyc;
      push_exp(1'b0, 2'b00, 1'b1, t + 2);
      push_exp(1'b0, 2'b00, 1'b1, t + 9);
      i_fire = 1'b1; tick(1); i_fire = 1'b0; tick(2);
      i_fire = 1'b1; tick(1); i_fire = 1'b0; tick(3);
      i_fire = 1'b1; tick(1); i_fire = 1'b0;
      tick(10);
      check_eq("fire_no_drop", 32'(o_drop_cnt), 32'd0);

      // 5: backpressure holds payload, fire during stall is dropped
      cmd_if.cmd_ready = 1'b0;
      t = cyc;
      i_down = 1'b1;
      tick(2);
      i_fire = 1'b1;
      tick(3);
      check_eq("bp_valid", 32'(cmd_if.cmd_valid), 32'd1);
      check_eq("bp_move", 32'(cmd_if.cmd_move), 32'd1);
      check_eq("bp_dir", 32'(cmd_if.cmd_dir), 32'd1);
      check_eq("bp_fire", 32'(cmd_if.cmd_fire), 32'd0);
      check_eq("bp_drop", 32'(o_drop_cnt), 32'd1);
      i_down = 1'b0;
      i_fire = 1'b0;
      tick(1);
      cmd_if.cmd_ready = 1'b1;
      push_exp(1'b1, 2'b01, 1'b0, cyc);
      tick(1);
      check_eq("bp_valid_after", 32'(cmd_if.cmd_valid), 32'd0);
      tick(8);
      check_eq("bp_drop_hold", 32'(o_drop_cnt), 32'd1);

      // 6: reset with pending command and left held through release
      cmd_if.cmd_ready = 1'b0;
      i_left = 1'b1;
      tick(3);
      check_eq("pre_rst_valid", 32'(cmd_if.cmd_valid), 32'd1);
      rst_n = 1'b0;
      tick(1);
      check_eq("in_rst_valid", 32'(cmd_if.cmd_valid), 32'd0);
      check_eq("in_rst_move", 32'(cmd_if.cmd_move), 32'd0);
      check_eq("in_rst_dir", 32'(cmd_if.cmd_dir), 32'd0);
      check_eq("in_rst_drop", 32'(o_drop_cnt), 32'd0);
      cmd_if.cmd_ready = 1'b1;
      tick(1);
      rst_n = 1'b1;
      push_exp(1'b1, 2'b10, 1'b0, cyc + 2);
      tick(3);
      i_left = 1'b0;
      tick(10);

      check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
